// File: rtl/blake2_pkg.sv
// Shared definitions for the BLAKE2 message packer: block geometry, FSM states
// and the byte-lane helper used to place message bytes inside a block.
package blake2_pkg;

  localparam int BLOCK_W     = 1024;
  localparam int BLOCK_BYTES = 128;
  localparam int LEN_W       = 64;
  localparam int PTR_W       = 7;

  typedef enum logic [2:0] {
    S_FILL,
    S_HOLD,
    S_ISSUE,
    S_BUSY_LO,
    S_BUSY_HI,
    S_WAIT_DGST,
    S_OUT
  } state_e;

  // Byte 0 sits in the top lane, so lane LSB = (127 - idx) * 8.
  function automatic logic [9:0] lane_lsb(input logic [PTR_W-1:0] idx);
    return {~idx, 3'b000};
  endfunction

endpackage

// File: rtl/blake2_block_buffer.sv
// 128-byte block register with a single byte write port and synchronous clear.
module blake2_block_buffer
  import blake2_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               wr_en_i,
  input  logic [PTR_W-1:0]   ptr_i,
  input  logic [7:0]         data_i,
  output logic [BLOCK_W-1:0] block_o
);

  logic [BLOCK_W-1:0] block_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      block_q <= '0;
    end else if (wr_en_i) begin
      block_q[lane_lsb(ptr_i) +: 8] <= data_i;
    end
  end

  assign block_o = block_q;

endmodule

// File: rtl/blake2_msg_packer.sv
// Packs a byte stream into 1024-bit BLAKE2 blocks, sequences the core and
// captures its digest. Optional cycle counter under BLAKE2_PACKER_PERF_EN.
//
// state       | meaning
// FILL        | accepting bytes into the block buffer
// HOLD        | block full, waiting to learn whether more data follows
// ISSUE       | waiting for core_ready, then pulse init/next
// BUSY_LO     | waiting for the core to drop ready
// BUSY_HI     | waiting for the core to finish the block
// WAIT_DGST   | final block done, waiting for the digest
// OUT         | digest presented until the consumer takes it
module blake2_msg_packer
  import blake2_pkg::*;
#(
  parameter int DIGEST_LENGTH = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       core_init,
  output logic                       core_next,
  output logic                       core_final_block,
  output logic [BLOCK_W-1:0]         core_block,
  output logic [LEN_W-1:0]           core_data_length,
  input  logic                       core_ready,
  input  logic [8*DIGEST_LENGTH-1:0] core_digest,
  input  logic                       core_digest_valid,
  output logic                       out_valid,
  output logic [8*DIGEST_LENGTH-1:0] out_digest,
`ifdef BLAKE2_PACKER_PERF_EN
  output logic [31:0]                perf_cycles,
`endif
  input  logic                       out_ready
);

  state_e                     state_q, state_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic                       final_q, final_d;
  logic                       first_q, first_d;
  logic                       armed_q;
  logic [8*DIGEST_LENGTH-1:0] digest_q;

  logic byte_acc, buf_clr, issue, digest_ld;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    final_d   = final_q;
    first_d   = first_q;
    byte_acc  = 1'b0;
    buf_clr   = 1'b0;
    issue     = 1'b0;
    digest_ld = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_FILL: begin
        in_ready = armed_q;
        if (in_valid && armed_q) begin
          byte_acc = 1'b1;
          ptr_d    = ptr_q + 7'd1;
          len_d    = len_q + 64'd1;
          final_d  = in_last;
          if (in_last) begin
            state_d = S_ISSUE;
          end else if (ptr_q == 7'd127) begin
            state_d = S_HOLD;
          end
        end
      end
      // The pending byte is left on the bus and taken once FILL resumes.
      S_HOLD: begin
        if (in_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (core_ready && !reset) begin
          issue   = 1'b1;
          first_d = 1'b0;
          state_d = S_BUSY_LO;
        end
      end
      S_BUSY_LO: begin
        if (!core_ready) state_d = S_BUSY_HI;
      end
      S_BUSY_HI: begin
        if (core_ready) begin
          if (final_q) begin
            state_d = S_WAIT_DGST;
          end else begin
            buf_clr = 1'b1;
            ptr_d   = '0;
            state_d = S_FILL;
          end
        end
      end
      S_WAIT_DGST: begin
        if (core_digest_valid) begin
          digest_ld = 1'b1;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          len_d   = '0;
          ptr_d   = '0;
          final_d = 1'b0;
          first_d = 1'b1;
          buf_clr = 1'b1;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FILL;
      ptr_q    <= '0;
      len_q    <= '0;
      final_q  <= 1'b0;
      first_q  <= 1'b1;
      armed_q  <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      final_q <= final_d;
      first_q <= first_d;
      armed_q <= 1'b1;
      if (digest_ld) digest_q <= core_digest;
    end
  end

  blake2_block_buffer u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (buf_clr),
    .wr_en_i (byte_acc),
    .ptr_i   (ptr_q),
    .data_i  (in_data),
    .block_o (core_block)
  );

  assign core_init        = issue && first_q;
  assign core_next        = issue && !first_q;
  assign core_final_block = issue && final_q;
  assign core_data_length = len_q;
  assign out_digest       = digest_q;

`ifdef BLAKE2_PACKER_PERF_EN
  logic [31:0] perf_q;
  logic        perf_run_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q     <= '0;
      perf_run_q <= 1'b0;
    end else if (byte_acc && (len_q == '0)) begin
      perf_q     <= '0;
      perf_run_q <= 1'b1;
    end else if (perf_run_q) begin
      if (perf_q != '1) perf_q <= perf_q + 32'd1;
      if (digest_ld) perf_run_q <= 1'b0;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_blake2_msg_packer.sv
// Directed bench for blake2_msg_packer: a message-level block model, a simple
// core stand-in, and one negedge compare process checking every core pulse.
module tb_blake2_msg_packer;

  localparam int DL       = 11;
  localparam int BUSY_CYC = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_last, in_ready;
  logic [7:0]        in_data;
  logic              core_init, core_next, core_final_block;
  logic [1023:0]     core_block;
  logic [63:0]       core_data_length;
  logic              core_ready, core_digest_valid;
  logic [8*DL-1:0]   core_digest;
  logic              out_valid, out_ready;
  logic [8*DL-1:0]   out_digest;

  always #5 clk = ~clk;

  blake2_msg_packer #(.DIGEST_LENGTH(DL)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_last           (in_last),
    .in_ready          (in_ready),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_final_block  (core_final_block),
    .core_block        (core_block),
    .core_data_length  (core_data_length),
    .core_ready        (core_ready),
    .core_digest       (core_digest),
    .core_digest_valid (core_digest_valid),
    .out_valid         (out_valid),
    .out_digest        (out_digest),
    .out_ready         (out_ready)
  );

  typedef struct {
    logic [1023:0] blk;
    logic [63:0]   len;
    logic          fin;
    logic          ini;
  } issue_t;

  issue_t        exp_q[$];
  issue_t        e_cur;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            acc_log[$];
  int            pulse_log[$];
  logic [63:0]   len_log[$];
  logic [1023:0] last_blk;
  logic [8*DL-1:0] exp_digest, stub_digest;
  int            dig_seen = 0;
  int            dig_want = 0;
  int            dv_cyc   = 0;
  int            ov_rise  = 0;
  logic          ov_prev  = 1'b0;
  logic          stub_fin;
  byte unsigned  msg[$];
  int            p0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int idx;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      idx = 0;
      for (int k = 0; k < 128; k++) begin
        if (act[1023-8*k -: 8] !== exp[1023-8*k -: 8]) begin
          idx = k;
          break;
        end
      end
      $display("FAIL %s: byte %0d got %02h expected %02h", name, idx,
               act[1023-8*idx -: 8], exp[1023-8*idx -: 8]);
    end
  endtask

  // Message-level model: split into 128-byte chunks, last chunk is final.
  task automatic expect_msg(input byte unsigned m[$]);
    int n;
    n = m.size();
    for (int base = 0; base < n; base += 128) begin
      issue_t e;
      e.blk = '0;
      for (int j = 0; j < 128 && base + j < n; j++) e.blk[1023-8*j -: 8] = m[base+j];
      e.len = 64'((base + 128 < n) ? base + 128 : n);
      e.fin = (base + 128 >= n);
      e.ini = (base == 0);
      exp_q.push_back(e);
    end
    dig_want++;
  endtask

  task automatic fill(input int n, input byte unsigned v);
    for (int i = 0; i < n; i++) msg.push_back(v);
  endtask

  task automatic send_msg(input byte unsigned m[$], input bit with_last);
    acc_log.delete();
    for (int i = 0; i < m.size(); i++) begin
      int k;
      in_valid = 1'b1;
      in_data  = m[i];
      in_last  = with_last && (i == m.size() - 1);
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 2000) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: byte %0d in_ready=0 expected 1", i);
      end
      acc_log.push_back(cyc);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_dig();
    int k;
    k = 0;
    while (dig_seen < dig_want && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (dig_seen < dig_want) begin
      n_tests++;
      n_fail++;
      $display("FAIL digest_timeout: got %0d digests expected %0d", dig_seen, dig_want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_digest(input logic [8*DL-1:0] d);
    stub_digest = d;
    exp_digest  = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd0);
    chk({tag, "_core_init"}, 128'(core_init), 128'd0);
    chk({tag, "_core_next"}, 128'(core_next), 128'd0);
    chk({tag, "_final"}, 128'(core_final_block), 128'd0);
    chk_blk({tag, "_core_block"}, core_block, '0);
    chk({tag, "_data_length"}, 128'(core_data_length), 128'd0);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_out_digest"}, 128'(out_digest), 128'd0);
  endtask

  // Core stand-in: drops ready after each pulse, returns a digest after a final block.
  initial begin
    core_ready        = 1'b1;
    core_digest_valid = 1'b0;
    core_digest       = '0;
    forever begin
      @(negedge clk);
      if (!reset && (core_init || core_next)) begin
        stub_fin = core_final_block;
        @(posedge clk);
        #1 core_ready = 1'b0;
        repeat (BUSY_CYC) @(posedge clk);
        #1 core_ready = 1'b1;
        if (stub_fin) begin
          repeat (2) @(posedge clk);
          #1;
          core_digest       = stub_digest;
          core_digest_valid = 1'b1;
          dv_cyc            = cyc;
          @(posedge clk);
          #1 core_digest_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (core_init || core_next) begin
        pulse_log.push_back(cyc);
        len_log.push_back(core_data_length);
        last_blk = core_block;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: got init=%0b next=%0b expected no pulse", core_init, core_next);
        end else begin
          e_cur = exp_q.pop_front();
          chk("pulse_kind", 128'({core_init, core_next}), 128'({e_cur.ini, !e_cur.ini}));
          chk("final_flag", 128'(core_final_block), 128'(e_cur.fin));
          chk("data_length", 128'(core_data_length), 128'(e_cur.len));
          chk_blk("block", core_block, e_cur.blk);
        end
      end else begin
        chk("final_without_pulse", 128'(core_final_block), 128'd0);
      end
      if (!core_ready) chk("in_ready_while_core_busy", 128'(in_ready), 128'd0);
      if (out_valid && !ov_prev) ov_rise = cyc;
      if (out_valid && out_ready) begin
        chk("digest", 128'(out_digest), 128'(exp_digest));
        dig_seen++;
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    set_digest('0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk_reset_outputs("por");
    @(negedge clk);
    chk("fill_after_reset", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;

    // "abc": single final init, issue one cycle after last byte
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    set_digest(88'hac7b0972cbd915185ac929);
    expect_msg(msg);
    p0 = pulse_log.size();
    send_msg(msg, 1'b1);
    wait_dig();
    chk("abc_pulses", 128'(pulse_log.size() - p0), 128'd1);
    chk("abc_issue_latency", 128'(pulse_log[$]), 128'(acc_log[$] + 1));
    chk("abc_msbs", 128'(last_blk[1023:1000]), 128'h616263);
    chk_blk("abc_tail_zero", {24'h0, last_blk[999:0]}, '0);
    chk("abc_len", 128'(len_log[$]), 128'd3);
    chk("abc_out_valid_latency", 128'(ov_rise), 128'(dv_cyc + 1));

    // 64 x 'a'
    msg.delete();
    fill(64, 8'h61);
    set_digest(88'hf8dbc62fc7a114a81a868a);
    expect_msg(msg);
    p0 = pulse_log.size();
    send_msg(msg, 1'b1);
    wait_dig();
    chk("a64_pulses", 128'(pulse_log.size() - p0), 128'd1);
    chk("a64_len", 128'(len_log[$]), 128'd64);

    // exactly 128 x 'a' with last on byte 128: no HOLD
    msg.delete();
    fill(128, 8'h61);
    set_digest(88'h112233445566778899aabb);
    expect_msg(msg);
    p0 = pulse_log.size();
    send_msg(msg, 1'b1);
    wait_dig();
    chk("a128_pulses", 128'(pulse_log.size() - p0), 128'd1);
    chk("a128_issue_latency", 128'(pulse_log[$]), 128'(acc_log[$] + 1));
    chk("a128_len", 128'(len_log[$]), 128'd128);

    // 128 x 'a' then "bbb": HOLD, non-final init, final next
    msg.delete();
    fill(128, 8'h61);
    fill(3, 8'h62);
    set_digest(88'h0102030405060708090a0b);
    expect_msg(msg);
    p0 = pulse_log.size();
    send_msg(msg, 1'b1);
    wait_dig();
    chk("a128b3_pulses", 128'(pulse_log.size() - p0), 128'd2);
    chk("a128b3_hold_busy_gap", 128'(acc_log[128] - acc_log[127]), 128'd8);
    chk("a128b3_len0", 128'(len_log[len_log.size()-2]), 128'd128);
    chk("a128b3_len1", 128'(len_log[$]), 128'd131);
    chk("a128b3_msbs", 128'(last_blk[1023:1000]), 128'h626262);

    // digest back-pressure: out_ready low for 10 cycles, next byte must wait
    out_ready = 1'b0;
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    set_digest(88'hac7b0972cbd915185ac929);
    expect_msg(msg);
    send_msg(msg, 1'b1);
    begin
      int k;
      k = 0;
      while (!out_valid && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("bp_out_valid_seen", 128'(out_valid), 128'd1);
    end
    msg.delete();
    msg.push_back(8'h61);
    expect_msg(msg);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'h61;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_digest", 128'(out_digest), 128'(88'hac7b0972cbd915185ac929));
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 set_digest(88'h0a0b0c0d0e0f1011121314);
    @(negedge clk);
    chk("bp_resume_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_dig();
    chk("bp_a_len", 128'(len_log[$]), 128'd1);

    // reset in the middle of a message
    msg.delete();
    fill(50, 8'h61);
    send_msg(msg, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;

    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    set_digest(88'hac7b0972cbd915185ac929);
    expect_msg(msg);
    p0 = pulse_log.size();
    send_msg(msg, 1'b1);
    wait_dig();
    chk("post_reset_pulses", 128'(pulse_log.size() - p0), 128'd1);
    chk("post_reset_len", 128'(len_log[$]), 128'd3);

    repeat (5) @(posedge clk);
    chk("expect_queue_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/blake2_msg_packer.md
# blake2_msg_packer

Upstream feeder for `blake2_core`. Accepts a message as a byte stream with valid/ready handshake and packs it into 1024-bit blocks. Drives the core's `init`/`next`/`final_block`/`block`/`data_length` controls with the running byte count. Captures the resulting digest into a registered output with its own valid/ready handshake. Only one message is in flight at a time.

## Interface
- `DIGEST_LENGTH`, default 11: digest size in bytes; must match the attached `blake2_core`.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: byte valid.
- `in_data` in 8: message byte.
- `in_last` in 1: final byte of the message, qualified by `in_valid`.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `core_init` out 1: one-cycle pulse; first block of a message.
- `core_next` out 1: one-cycle pulse; each later block.
- `core_final_block` out 1: high only in the same cycle as an `init`/`next` pulse whose block is the last one.
- `core_block` out 1024: packed block; byte 0 at [1023:1016].
- `core_data_length` out 64: total message bytes consumed up to and including this block.
- `core_ready` in 1: core idle.
- `core_digest` in 8*DIGEST_LENGTH: core digest.
- `core_digest_valid` in 1: core digest valid.
- `out_valid` out 1: digest available.
- `out_digest` out 8*DIGEST_LENGTH: captured digest.
- `out_ready` in 1: consumer accepts the digest when `out_valid && out_ready`.

## Operation
- States: FILL, HOLD, ISSUE, BUSY_LO, BUSY_HI, WAIT_DGST, OUT.
- FILL: `in_ready`=1. Each accepted byte is written at index `ptr` (byte k at bits [1023-8k -: 8]); `ptr`++ and `len`++.
  - Accepted byte with `in_last` → ISSUE, final.
  - Accepted byte that fills position 127 without `in_last` → HOLD.
- HOLD: `in_ready`=0 while the full block waits to learn whether more data follows. BLAKE2 requires that the last block be flagged final, so a full block is not issued until this is known.
  - `in_valid`=1 → ISSUE, non-final. The byte is not consumed here; it is accepted later in FILL.
- ISSUE: waits for `core_ready`=1, then pulses `core_init` (first block of the message) or `core_next` (later blocks) for exactly one cycle. `core_final_block` equals the final flag in that cycle → BUSY_LO.
- BUSY_LO: waits for `core_ready`=0 → BUSY_HI.
- BUSY_HI: waits for `core_ready`=1.
  - Non-final block: zero the buffer, `ptr`=0 → FILL.
  - Final block → WAIT_DGST.
- WAIT_DGST: on `core_digest_valid`=1, register `core_digest` → OUT.
- OUT: `out_valid`=1 until `out_ready`. Then clear `len`, clear the buffer and the first-block flag → FILL.
- Unwritten bytes of a partial block are always zero.
- `core_block` and `core_data_length` stay stable from ISSUE through BUSY_HI.
- `len` is 64 bits and does not wrap within a legal message.
- Zero-length messages are not supported; `in_last` always accompanies a byte.

## Timing
- Reset values: `in_ready`=0 (FILL entered the cycle after reset deasserts), all core controls 0, `core_block`=0, `core_data_length`=0, `out_valid`=0, `out_digest`=0.
- Last byte accepted at cycle t → `core_init`/`core_next` at t+1 at the earliest (if `core_ready`=1).
- `core_digest_valid` at cycle d → `out_valid` at d+1.
- After each non-final block returns, the next byte is accepted one cycle after BUSY_HI completes.
- `reset` mid-operation: return to the reset state within one cycle. Any in-flight message is discarded; no further pulses go to the core.
- `out_ready` held high in OUT: the handshake completes in one cycle, and FILL resumes the next cycle.

## Configuration
- `BLAKE2_PACKER_PERF_EN` defined: adds output `perf_cycles` [31:0].
  - Counts cycles from the first accepted byte of a message to the `out_valid` rise.
  - Holds its value until the next message's first byte; reset value 0; saturates at all-ones.
- `BLAKE2_PACKER_PERF_EN` undefined: the port and counter are absent.

## Structure
- Shared package `blake2_pkg`:
  - block width 1024, bytes per block 128, length width 64;
  - the state enum;
  - the byte-lane index helper.
- Natural sub-module: `blake2_block_buffer`, a 128-byte register file with byte write at `ptr` and synchronous clear.

## Test plan
- "abc" (3 bytes, `in_last` on the third) → single `core_init` with `final_block`=1; block MSBs 0x616263, rest 0; `data_length`=3; digest 0xac7b0972cbd915185ac929.
- 64 × 0x61 → single init/final; `data_length`=64; digest 0xf8dbc62fc7a114a81a868a.
- Exactly 128 × 0x61 with `in_last` on byte 128 → one `core_init`, final, `data_length`=128; HOLD never entered.
- 128 × 0x61 then "bbb" → `core_init` non-final with `data_length`=128; then `core_next` final with block MSBs 0x626262 and `data_length`=131; `in_ready`=0 during HOLD and BUSY.
- `out_ready`=0 for 10 cycles after digest → `out_valid` and `out_digest` stable throughout; no new byte accepted until the handshake completes.
- `reset` asserted after 50 bytes of a message → next cycle all outputs at reset values; a following "abc" message hashes correctly.
